// File: rtl/inst_cache_if.sv
// Bus bundle between the instruction cache, the IF stage and the memory
// controller. The slave view is the cache; the master view is everything
// around it (IF stage plus memory controller).
interface inst_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    // IF side
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_valid_o;
    logic [31:0]           if_inst_o;
    logic [ADDR_WIDTH-1:0] if_addr_o;
    logic                  busy_o;
    // Memory controller side
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_valid;
    logic [31:0]           mem_inst;

    modport slave (
        input  if_req, if_addr, mem_valid, mem_inst,
        output if_valid_o, if_inst_o, if_addr_o, busy_o, mem_req, mem_addr
    );

    modport master (
        output if_req, if_addr, mem_valid, mem_inst,
        input  if_valid_o, if_inst_o, if_addr_o, busy_o, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer one cycle
// after the request; misses hold a refill request until the memory controller
// returns the word, then fill the line and forward the word to IF. A flush
// drops any outstanding lookup or refill.
module inst_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    inst_cache_if.slave bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Line storage kept in flops so every valid bit can be cleared in one cycle.
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic                  if_valid_q, if_valid_d;
    logic [31:0]           if_inst_q,  if_inst_d;
    logic [ADDR_WIDTH-1:0] if_addr_q,  if_addr_d;
    logic                  mem_req_q,  mem_req_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]           hit_cnt_q,  hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;
    logic                  fill_en;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  lookup_hit;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;

    assign lookup_idx = bus.if_addr[INDEX_BITS+1:2];
    assign lookup_tag = bus.if_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign lookup_hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
    assign fill_idx   = req_addr_q[INDEX_BITS+1:2];
    assign fill_tag   = req_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

    // State and registered outputs; reset zeroes every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_addr_q  <= '0;
            mem_req_q  <= 1'b0;
            req_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_addr_q  <= if_addr_d;
            mem_req_q  <= mem_req_d;
            req_addr_q <= req_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state logic: lookup in IDLE, wait for refill data in MISS.
    always_comb begin
        state_d    = state_q;
        if_valid_d = 1'b0;
        if_inst_d  = if_inst_q;
        if_addr_d  = if_addr_q;
        mem_req_d  = mem_req_q;
        req_addr_d = req_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        fill_en    = 1'b0;
        case (state_q)
            IDLE: begin
                // A lookup presented alongside flush is discarded outright.
                if (bus.if_req && !flush) begin
                    if (lookup_hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_q[lookup_idx];
                        if_addr_d  = bus.if_addr;
                        hit_cnt_d  = hit_cnt_q + 32'd1;
                    end else begin
                        mem_req_d  = 1'b1;
                        req_addr_d = bus.if_addr;
                        miss_cnt_d = miss_cnt_q + 32'd1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                if (bus.mem_valid) begin
                    // Returned data is correct for req_addr even under flush,
                    // so the line is filled; only the forward is suppressed.
                    fill_en   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!flush) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = bus.mem_inst;
                        if_addr_d  = req_addr_q;
                    end
                end else if (flush) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid bits: cleared together on reset, set by a refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written on refill, overwriting whatever was there.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.mem_inst;
        end
    end

    assign bus.if_valid_o = if_valid_q;
    assign bus.if_inst_o  = if_inst_q;
    assign bus.if_addr_o  = if_addr_q;
    assign bus.busy_o     = mem_req_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;
endmodule
